instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter AW, default 8: width of the program counter and memory address.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 run  input  1  fetch enable; level-sensitive.
REQ-005 w  input  1  from the controller; 1 = controller idle (WAIT/DECODE), 0 = executing.
REQ-006 mem_rdata  input  16  instruction word, valid the cycle after mem_rd is asserted.
REQ-007 mem_addr  output  AW  instruction address; equals pc.
REQ-008 mem_rd  output  1  memory read strobe.
REQ-009 s  output  1  start pulse to the controller.
REQ-010 opcode  output  3  IR[15:13].
REQ-011 op  output  2  IR[12:11].
REQ-012 ir  output  16  instruction register.
REQ-013 pc  output  AW  program counter.
REQ-014 halted  output  1  sticky halt flag.
REQ-015 err  output  1  sticky trap flag.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, LATCH, ISSUE, WAIT_BUSY, WAIT_DONE, HALT and TRAP.
REQ-017 IDLE: mem_rd=0, s=0; go to FETCH when run=1, else stay in IDLE.
REQ-018 FETCH: mem_rd=1 for exactly one cycle with mem_addr=pc; next state is LATCH.
REQ-019 LATCH: ir <= mem_rdata; the next state is decoded from mem_rdata in the same cycle.
REQ-020 LATCH decode: opcode 111 -> HALT; legal (110 with op 10 or 00; 101 with any op) -> ISSUE; all others -> TRAP.
REQ-021 ISSUE: s=1 for exactly one cycle; next state is WAIT_BUSY; s SHALL be 0 in every other state.
REQ-022 WAIT_BUSY: a 3-bit timeout counter is cleared on entry and increments each cycle w=1; w=0 -> WAIT_DONE; counter reaching 7 with w=1 -> TRAP.
REQ-023 WAIT_DONE: w=1 -> pc <= pc+1, wrapping 2^AW-1 -> 0; then go to FETCH if run=1, else IDLE; w=0 -> stay.
REQ-024 HALT: halted=1; pc and ir are held; remain in HALT until reset, ignoring run and w.
REQ-025 TRAP: err=1; pc is held at the offending instruction; remain in TRAP until reset.
REQ-026 ir, opcode and op SHALL be stable from the LATCH edge through WAIT_DONE.
REQ-027 run deasserted mid-instruction: the current instruction completes, pc increments, then the FSM enters IDLE.
REQ-028 Changes on w are ignored outside WAIT_BUSY and WAIT_DONE.
REQ-029 Minimum instruction period is 6 cycles: FETCH, LATCH, ISSUE, WAIT_BUSY×2, and at least 1 WAIT_DONE cycle.

Reset
REQ-030 reset=1 at a clock edge SHALL force state=IDLE, pc=0, ir=0, timeout counter=0, halted=0 and err=0, from any state, including mid-instruction.
REQ-031 While in reset: mem_rd=0 and s=0; a pending controller handshake is abandoned.

Verification
REQ-032 Reset, run=1, mem[0]=16'hD000 (opcode 110, op 10), controller model drops w 2 cycles after s -> mem_rd at addr 0, s pulse of one cycle, pc=1 after w returns high.
REQ-033 mem[1]=16'hE000 (opcode 111) -> halted=1, s never asserted, pc stays 1 over 20 cycles while run=1.
REQ-034 mem[0]=16'h0000 (opcode 000) -> err=1 one cycle after LATCH, no s pulse; a subsequent reset clears err and pc.
REQ-035 Legal instruction with w held at 1 after s -> TRAP after 7 WAIT_BUSY cycles, err=1.
REQ-036 AW=8, pc=255, legal instruction completes -> pc=0 and next mem_addr=0; run=0 during WAIT_BUSY -> FSM enters IDLE after completion with no further mem_rd.
REQ-037 Reset asserted during WAIT_DONE -> next cycle state=IDLE, pc=0, ir=0, s=0, mem_rd=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: fetches the word at pc, classifies it, starts the
// controller and waits for its busy/done handshake before advancing pc.
module instr_fetch #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          w,
  input  logic [15:0]   mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          s,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [15:0]   ir,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HALT,
    TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [2:0]    tmo_q, tmo_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;

  logic [2:0]    rd_opcode;
  logic [1:0]    rd_op;
  logic          rd_legal;

  // Decode straight from the memory word so the branch is taken in LATCH itself.
  assign rd_opcode = mem_rdata[15:13];
  assign rd_op     = mem_rdata[12:11];
  assign rd_legal  = (rd_opcode == 3'b101) || ((rd_opcode == 3'b110) && !rd_op[0]);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    tmo_d    = tmo_q;
    halted_d = halted_q;
    err_d    = err_q;
    mem_rd   = 1'b0;
    s        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        mem_rd  = !reset;
        state_d = LATCH;
      end
      LATCH: begin
        ir_d = mem_rdata;
        if (rd_opcode == 3'b111) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (rd_legal) begin
          state_d = ISSUE;
        end else begin
          state_d = TRAP;
          err_d   = 1'b1;
        end
      end
      ISSUE: begin
        s       = !reset;
        tmo_d   = 3'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // The controller must acknowledge by dropping w within seven cycles.
        if (!w) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 3'd1;
          if (tmo_q == 3'd6) begin
            state_d = TRAP;
            err_d   = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (w) begin
          pc_d    = pc_q + AW'(1);
          state_d = run ? FETCH : IDLE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      tmo_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      tmo_q    <= tmo_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign opcode   = ir_q[15:13];
  assign op       = ir_q[12:11];
  assign halted   = halted_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory and controller responders, an instruction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        w = 1'b1;
  logic [15:0] mem_rdata = 16'hFFFF;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        s;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic        halted;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_model_prints = 0;

  logic [15:0] mem [0:255];

  instr_fetch #(.AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .w         (w),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .s         (s),
    .opcode    (opcode),
    .op        (op),
    .ir        (ir),
    .pc        (pc),
    .halted    (halted),
    .err       (err)
  );

  initial forever #5 clk = ~clk;

  // Memory answers one cycle after the read strobe; otherwise it shows a halt word.
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 16'hFFFF;

  // Controller: w goes low ctrl_delay cycles after s, for ctrl_hold cycles.
  int since = -1;
  bit ctrl_drop = 1'b1;
  int ctrl_delay = 2;
  int ctrl_hold = 1;

  always @(negedge clk) begin
    if (reset) since = -1;
    else if (s) since = 0;
    else if (since >= 0) since++;
  end

  always @(posedge clk) begin
    #1;
    w = !(ctrl_drop && since >= 0 && since + 1 >= ctrl_delay && since + 1 < ctrl_delay + ctrl_hold);
  end

  function automatic bit is_legal(input logic [15:0] instr);
    case (instr[15:11])
      5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11000, 5'b11010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: m_tick counts cycles since the fetch began (-1 = nothing in flight).
  int          m_tick = -1;
  bit          m_low = 1'b0;
  int          m_busy = 0;
  logic [7:0]  m_pc = 8'd0;
  logic [15:0] m_ir = 16'd0;
  bit          m_halted = 1'b0;
  bit          m_err = 1'b0;
  bit          chk_en = 1'b0;
  logic        exp_rd, exp_s;

  always @(negedge clk) begin
    exp_rd = !reset && !m_halted && !m_err && (m_tick == 0);
    exp_s  = !reset && !m_halted && !m_err && (m_tick == 2);
    if (chk_en) begin
      n_checks++;
      if ({mem_rd, s, mem_addr, pc, ir, opcode, op, halted, err} !==
          {exp_rd, exp_s, m_pc, m_pc, m_ir, m_ir[15:13], m_ir[12:11], m_halted, m_err}) begin
        n_fail++;
        if (n_model_prints < 20) begin
          n_model_prints++;
          $display("FAIL model_cycle t=%0t got rd=%b s=%b addr=%0d pc=%0d ir=%h h=%b e=%b expected rd=%b s=%b addr=%0d pc=%0d ir=%h h=%b e=%b",
                   $time, mem_rd, s, mem_addr, pc, ir, halted, err,
                   exp_rd, exp_s, m_pc, m_pc, m_ir, m_halted, m_err);
        end
      end
    end
    if (reset) begin
      m_tick = -1; m_low = 1'b0; m_busy = 0;
      m_pc = 8'd0; m_ir = 16'd0; m_halted = 1'b0; m_err = 1'b0;
      chk_en = 1'b1;
    end else if (m_halted || m_err) begin
      m_tick = -1;
    end else if (m_tick < 0) begin
      if (run) m_tick = 0;
    end else if (m_tick == 0) begin
      m_tick = 1;
    end else if (m_tick == 1) begin
      m_ir = mem[m_pc];
      if (m_ir[15:13] == 3'b111) begin
        m_halted = 1'b1; m_tick = -1;
      end else if (!is_legal(m_ir)) begin
        m_err = 1'b1; m_tick = -1;
      end else begin
        m_tick = 2;
      end
    end else if (m_tick == 2) begin
      $display("issue pc=%0d ir=%h", m_pc, m_ir);
      m_tick = 3; m_low = 1'b0; m_busy = 0;
    end else if (!m_low) begin
      if (!w) begin
        m_low = 1'b1;
      end else begin
        m_busy++;
        if (m_busy == 7) begin m_err = 1'b1; m_tick = -1; end
      end
    end else if (w) begin
      m_pc = m_pc + 8'd1;
      m_tick = run ? 0 : -1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    next();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_flags", {halted, err, mem_rd, s}, 0);
    next();
    reset = 1'b0;
  endtask

  task automatic wait_fetch(input logic [7:0] a, input int budget, input string nm);
    int n;
    n = 0;
    while (!(mem_rd === 1'b1 && mem_addr == a) && n < budget) begin
      next();
      n++;
    end
    check(nm, (n < budget) ? 1 : 0, 1);
  endtask

  logic [15:0] legal_tab [0:5];
  int cnt;

  initial begin
    legal_tab[0] = 16'hA000; legal_tab[1] = 16'hA800; legal_tab[2] = 16'hB000;
    legal_tab[3] = 16'hB800; legal_tab[4] = 16'hC000; legal_tab[5] = 16'hD000;
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;

    // Legal instruction then halt.
    mem[0] = 16'hD000;
    mem[1] = 16'hE000;
    do_reset();
    run = 1'b1;
    check("a_idle_no_rd", mem_rd, 0);
    next();
    check("a_fetch_rd", mem_rd, 1);
    check("a_fetch_addr", mem_addr, 0);
    next();
    check("a_latch_s", s, 0);
    next();
    check("a_issue_s", s, 1);
    check("a_ir", ir, 16'hD000);
    check("a_opcode", opcode, 3'b110);
    check("a_op", op, 2'b10);
    next();
    check("a_s_one_cycle", s, 0);
    next(); next(); next();
    check("a_pc_inc", pc, 1);
    check("a_fetch1", {mem_rd, mem_addr}, {1'b1, 8'd1});
    next();
    check("a_halted_latch", halted, 0);
    next();
    check("a_halted", halted, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      next();
      if (s || mem_rd) cnt++;
    end
    check("a_halt_quiet", cnt, 0);
    check("a_halt_pc", pc, 1);
    check("a_halt_ir", ir, 16'hE000);

    // Illegal opcode traps.
    mem[0] = 16'h0000;
    do_reset();
    run = 1'b1;
    next(); next();
    check("b_err_latch", err, 0);
    next();
    check("b_err", err, 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      next();
      if (s) cnt++;
    end
    check("b_no_s", cnt, 0);
    do_reset();
    check("b_err_cleared", {err, pc}, 0);

    // Controller never acknowledges: timeout trap.
    mem[0] = 16'hA000;
    ctrl_drop = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 10; i++) next();
    check("c_err_before", err, 0);
    next();
    check("c_err_timeout", err, 1);
    check("c_pc_held", pc, 0);
    ctrl_drop = 1'b1;

    // Run to pc=255, drop run mid-instruction, observe wrap.
    for (int i = 0; i < 256; i++) mem[i] = legal_tab[i % 6] | 16'(i);
    ctrl_hold = 2;
    do_reset();
    run = 1'b1;
    wait_fetch(8'd255, 3000, "d_reach_255");
    check("d_pc255", pc, 255);
    next(); next(); next();
    run = 1'b0;
    next(); next(); next();
    check("d_pc_before_wrap", pc, 255);
    next();
    check("d_pc_wrap", pc, 0);
    check("d_addr_wrap", mem_addr, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      next();
      if (mem_rd) cnt++;
    end
    check("d_idle_no_rd", cnt, 0);
    run = 1'b1;
    next();
    check("d_refetch0", {mem_rd, mem_addr}, {1'b1, 8'd0});

    // Reset during WAIT_DONE, then reset during FETCH.
    wait_fetch(8'd3, 100, "e_reach_3");
    ctrl_hold = 10;
    next(); next(); next(); next(); next(); next();
    check("e_pc3", pc, 3);
    reset = 1'b1;
    #1;
    check("e_rst_outs", {mem_rd, s}, 0);
    next();
    check("e_after_rst", {pc, ir, s, mem_rd}, 0);
    reset = 1'b0;
    next();
    check("e_fetch_after", {mem_rd, mem_addr}, {1'b1, 8'd0});
    reset = 1'b1;
    #1;
    check("e_rd_gated", mem_rd, 0);
    next();
    reset = 1'b0;
    run = 1'b0;
    next(); next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t required finish before it", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
